// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I issue/collect controller driving an external ALU
//
// Accepts one instruction plus operands, decodes it into registered ALU
// operands/opcode, captures the ALU result one cycle later, resolves branch
// conditions and returns everything over a valid/ready response port.
//
// Ports:
//   clk_i, rst_i                    clock (rising edge), async active-high reset
//   in_valid_i / in_ready_o         instruction handshake
//   instr_i, pc_i                   instruction word and its PC
//   rs1_data_i, rs2_data_i          register operands
//   srcA_o, srcB_o, ALUCtrl_o       registered ALU operands and opcode
//   ALUResult_i, Zero_i             combinational ALU result and zero flag
//   out_valid_o / out_ready_i       response handshake
//   result_o                        captured ALU result (0 for branch/illegal)
//   is_branch_o, branch_taken_o     branch flags
//   branch_target_o                 pc_i + B-immediate
//   illegal_o                       unsupported opcode/funct

module alu_issue_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [31:0]           pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic [DATA_WIDTH-1:0] srcA_o,
  output logic [DATA_WIDTH-1:0] srcB_o,
  output logic [3:0]            ALUCtrl_o,
  input  logic [DATA_WIDTH-1:0] ALUResult_i,
  input  logic                  Zero_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  is_branch_o,
  output logic                  branch_taken_o,
  output logic [31:0]           branch_target_o,
  output logic                  illegal_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [1:0] state_q;
  logic [2:0] br_funct3_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       funct7_ok;

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] shamt_z;
  logic [31:0]           imm_b;
  logic [31:0]           br_target_sum;

  logic [DATA_WIDTH-1:0] dec_src_a;
  logic [DATA_WIDTH-1:0] dec_src_b;
  logic [3:0]            dec_ctrl;
  logic                  dec_branch;
  logic                  dec_illegal;

  logic accept;
  logic br_cond;

  // rs1 index field is consumed upstream (register read); only its value arrives here.
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr_i[19:15];

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign funct7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);

  assign imm_i   = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
  assign shamt_z = {{(DATA_WIDTH-SHIFT_WIDTH){1'b0}}, instr_i[20 +: SHIFT_WIDTH]};
  assign imm_b   = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};

  // Dedicated target adder so the ALU is free to evaluate the branch compare.
  assign br_target_sum = pc_i + imm_b;

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_RESP);
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    dec_src_a   = rs1_data_i;
    dec_src_b   = rs2_data_i;
    dec_ctrl    = ALU_ADD;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      OP_R: begin
        // The alternate funct7 only exists for SUB and SRA.
        if (!funct7_ok) begin
          dec_illegal = 1'b1;
        end else if (funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          dec_illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  dec_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  dec_ctrl = ALU_SLL;
            3'b010:  dec_ctrl = ALU_SLT;
            3'b011:  dec_ctrl = ALU_SLTU;
            3'b100:  dec_ctrl = ALU_XOR;
            3'b101:  dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  dec_ctrl = ALU_OR;
            default: dec_ctrl = ALU_AND;
          endcase
        end
      end

      OP_I: begin
        dec_src_b = imm_i;
        case (funct3)
          3'b000: dec_ctrl = ALU_ADD;
          3'b010: dec_ctrl = ALU_SLT;
          3'b011: dec_ctrl = ALU_SLTU;
          3'b100: dec_ctrl = ALU_XOR;
          3'b110: dec_ctrl = ALU_OR;
          3'b111: dec_ctrl = ALU_AND;
          3'b001: begin
            dec_src_b   = shamt_z;
            dec_ctrl    = ALU_SLL;
            dec_illegal = !funct7_ok;
          end
          default: begin
            // 101: instr[30] picks arithmetic vs logical right shift.
            dec_src_b   = shamt_z;
            dec_ctrl    = instr_i[30] ? ALU_SRA : ALU_SRL;
            dec_illegal = !funct7_ok;
          end
        endcase
      end

      OP_B: begin
        dec_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_ctrl = ALU_SUB;
          3'b100, 3'b101: dec_ctrl = ALU_SLT;
          3'b110, 3'b111: dec_ctrl = ALU_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end

      default: dec_illegal = 1'b1;
    endcase

    // Illegal instructions still flow through EXEC/RESP as a harmless 0+0.
    if (dec_illegal) begin
      dec_src_a  = '0;
      dec_src_b  = '0;
      dec_ctrl   = ALU_ADD;
      dec_branch = 1'b0;
    end
  end

  // SUB compares (BEQ/BNE) set Zero on equality; SLT/SLTU compares clear
  // Zero when the "less than" relation holds.
  always_comb begin
    case (br_funct3_q)
      3'b000:         br_cond = Zero_i;
      3'b001:         br_cond = !Zero_i;
      3'b100, 3'b110: br_cond = !Zero_i;
      3'b101, 3'b111: br_cond = Zero_i;
      default:        br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      br_funct3_q     <= '0;
      srcA_o          <= '0;
      srcB_o          <= '0;
      ALUCtrl_o       <= ALU_ADD;
      result_o        <= '0;
      is_branch_o     <= 1'b0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
      illegal_o       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            srcA_o          <= dec_src_a;
            srcB_o          <= dec_src_b;
            ALUCtrl_o       <= dec_ctrl;
            is_branch_o     <= dec_branch;
            illegal_o       <= dec_illegal;
            branch_target_o <= dec_branch ? br_target_sum : 32'd0;
            br_funct3_q     <= funct3;
            result_o        <= '0;
            branch_taken_o  <= 1'b0;
            state_q         <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          result_o       <= (is_branch_o || illegal_o) ? '0 : ALUResult_i;
          branch_taken_o <= is_branch_o && br_cond;
          state_q        <= ST_RESP;
        end

        ST_RESP: begin
          if (out_ready_i) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed vector bench for alu_issue_ctrl with a behavioural ALU

module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        is_branch;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        illegal;

  int errors = 0;
  int checks = 0;
  int tag    = -1;

  alu_issue_ctrl #(.DATA_WIDTH(32), .SHIFT_WIDTH(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .instr_i        (instr),
    .pc_i           (pc),
    .rs1_data_i     (rs1),
    .rs2_data_i     (rs2),
    .srcA_o         (src_a),
    .srcB_o         (src_b),
    .ALUCtrl_o      (alu_ctrl),
    .ALUResult_i    (alu_result),
    .Zero_i         (alu_zero),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result),
    .is_branch_o    (is_branch),
    .branch_taken_o (branch_taken),
    .branch_target_o(branch_target),
    .illegal_o      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real datapath.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      4'b0110: alu_result = (src_a < src_b) ? 32'd1 : 32'd0;
      4'b0111: alu_result = src_a >> src_b[4:0];
      4'b1000: alu_result = src_a << src_b[4:0];
      4'b1001: alu_result = $unsigned($signed(src_a) >>> src_b[4:0]);
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [31:0] srcb;
    logic [31:0] result;
    logic        br;
    logic        taken;
    logic [31:0] target;
    logic        ill;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    instr = v.instr;
    pc    = v.pc;
    rs1   = v.rs1;
    rs2   = v.rs2;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("exec_out_valid", {31'd0, out_valid}, 32'd0);
    check("exec_in_ready", {31'd0, in_ready}, 32'd0);
    check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, v.ctrl});
    check("src_a", src_a, v.ill ? 32'd0 : v.rs1);
    check("src_b", src_b, v.srcb);
    tick();
    check("resp_out_valid", {31'd0, out_valid}, 32'd1);
    check("result", result, v.result);
    check("is_branch", {31'd0, is_branch}, {31'd0, v.br});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, v.taken});
    check("branch_target", branch_target, v.target);
    check("illegal", {31'd0, illegal}, {31'd0, v.ill});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("done_out_valid", {31'd0, out_valid}, 32'd0);
    check("done_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    //            instr         pc            rs1           rs2           ctrl   srcb          result        br    tk    target        ill
    vecs[0]  = '{32'h002081B3, 32'h0,        32'd5,        32'd7,        4'h0, 32'd7,        32'd12,       1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{32'h402081B3, 32'h0,        32'd5,        32'd7,        4'h1, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{32'h4040D093, 32'h0,        32'h80000000, 32'h0,        4'h9, 32'd4,        32'hF8000000, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{32'hFFF08093, 32'h0,        32'd10,       32'd3,        4'h0, 32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{32'h0020C1B3, 32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 4'h4, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{32'h0020B1B3, 32'h0,        32'd1,        32'hFFFFFFFF, 4'h6, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{32'h0020C863, 32'h100,      32'hFFFFFFFF, 32'd1,        4'h5, 32'd1,        32'd0,        1'b1, 1'b1, 32'h110,      1'b0};
    vecs[7]  = '{32'h0020C863, 32'h100,      32'd1,        32'hFFFFFFFF, 4'h5, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 32'h110,      1'b0};
    vecs[8]  = '{32'hFE208CE3, 32'h200,      32'd42,       32'd42,       4'h1, 32'd42,       32'd0,        1'b1, 1'b1, 32'h1F8,      1'b0};
    vecs[9]  = '{32'hFE209CE3, 32'h4,        32'd42,       32'd42,       4'h1, 32'd42,       32'd0,        1'b1, 1'b0, 32'hFFFFFFFC, 1'b0};
    vecs[10] = '{32'h0000007F, 32'h300,      32'd123,      32'd456,      4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 32'h0,        1'b1};
    vecs[11] = '{32'h022081B3, 32'h0,        32'd6,        32'd7,        4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 32'h0,        1'b1};
    vecs[12] = '{32'h0020A863, 32'h100,      32'd1,        32'd2,        4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 32'h0,        1'b1};
    vecs[13] = '{32'h02409093, 32'h0,        32'd8,        32'd0,        4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 32'h0,        1'b1};
    vecs[14] = '{32'h0020D1B3, 32'h0,        32'h80000000, 32'h24,       4'h7, 32'h24,       32'h08000000, 1'b0, 1'b0, 32'h0,        1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1       = '0;
    rs2       = '0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_src_a", src_a, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_target", branch_target, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      tag = i;
      run_vec(vecs[i]);
    end

    // Backpressure: response held, new request waits.
    tag = 100;
    drive(vecs[0]);
    in_valid = 1'b1;
    tick();
    instr = 32'h402081B3;
    rs1   = 32'd20;
    rs2   = 32'd3;
    check("bp_exec_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_result", result, 32'd12);
      check("bp_src_a", src_a, 32'd5);
      check("bp_ctrl", {28'd0, alu_ctrl}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_next_src_a", src_a, 32'd20);
    check("bp_next_ctrl", {28'd0, alu_ctrl}, 32'd1);
    tick();
    check("bp_next_result", result, 32'd17);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while in EXEC.
    tag = 200;
    drive(vecs[0]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre_rst_src_a", src_a, 32'd5);
    rst = 1'b1;
    #1;
    check("rst_exec_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_exec_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_exec_src_a", src_a, 32'd0);
    tick();
    check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold_result", result, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back with in_valid held and out_ready=1.
    tag = 300;
    begin
      int n_acc;
      int n_res;
      int last_acc;
      n_acc    = 0;
      n_res    = 0;
      last_acc = -1;
      instr     = 32'h002081B3;
      rs2       = 32'd1;
      rs1       = 32'd100;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
        if (in_ready) begin
          rs1 = 32'd100 + 32'(n_acc);
          if (n_acc > 0) check("b2b_gap", 32'(c - last_acc), 32'd3);
          last_acc = c;
          n_acc++;
        end
        if (out_valid) begin
          check("b2b_result", result, 32'd101 + 32'(n_res));
          n_res++;
        end
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_accepts", 32'(n_acc), 32'd4);
      check("b2b_results", 32'(n_res), 32'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
